// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode 7-segment driver.
// Shadow/active code sets give tear-free frame-synchronous updates; each
// digit slot starts with an all-anodes-off guard window against ghosting.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zeros).
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 2000,
    parameter int BLINK_FRAMES = 50
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    // Active-low patterns {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'h0:    decode = 7'b1000000;
            4'h1:    decode = 7'b1111001;
            4'h2:    decode = 7'b0100100;
            4'h3:    decode = 7'b0110000;
            4'h4:    decode = 7'b0011001;
            4'h5:    decode = 7'b0010010;
            4'h6:    decode = 7'b0000010;
            4'h7:    decode = 7'b1111000;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0010000;
            4'hA:    decode = 7'b0001000;  // A
            4'hB:    decode = 7'b1000111;  // L
            4'hC:    decode = 7'b1111001;  // I, drawn like 1
            4'hD:    decode = 7'b0001110;  // F
            4'hE:    decode = 7'b0111111;  // '-'
            default: decode = 7'b1111111;  // blank
        endcase
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             blink_ph_q, blink_ph_d;
    logic             pending_q, pending_d;
    logic [NUM_DIGITS-1:0][3:0] sh_code_q, sh_code_d, act_code_q, act_code_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0] sh_blink_q, sh_blink_d, act_blink_q, act_blink_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  tick_q, tick_d;
    logic                  slot_wrap, frame_end;
    logic [NUM_DIGITS-1:0] lz_sup;

    // Scan counters, blink phase and shadow/active register sets
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        blk_cnt_d    = blk_cnt_q;
        blink_ph_d   = blink_ph_q;
        pending_d    = pending_q;
        sh_code_d    = sh_code_q;
        sh_dp_d      = sh_dp_q;
        sh_blank_d   = sh_blank_q;
        sh_blink_d   = sh_blink_q;
        act_code_d   = act_code_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        act_blink_d  = act_blink_q;
        slot_wrap    = (cnt_q == CNT_LAST);
        frame_end    = slot_wrap && (idx_q == IDX_LAST);

        cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (frame_end) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_d  = '0;
                blink_ph_d = ~blink_ph_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end

        if (load) begin
            sh_code_d  = digits;
            sh_dp_d    = dp_in;
            sh_blank_d = blank_mask;
            sh_blink_d = blink_mask;
        end
        // A load on the frame-end cycle bypasses the shadow so it shows next frame
        if (frame_end && load) begin
            act_code_d  = digits;
            act_dp_d    = dp_in;
            act_blank_d = blank_mask;
            act_blink_d = blink_mask;
            pending_d   = 1'b0;
        end else if (frame_end && pending_q) begin
            act_code_d  = sh_code_q;
            act_dp_d    = sh_dp_q;
            act_blank_d = sh_blank_q;
            act_blink_d = sh_blink_q;
            pending_d   = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Leading-zero suppression mask over the active code set
    always_comb begin
        lz_sup = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic hi_ok;
            hi_ok = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                lz_sup[i] = hi_ok && (act_code_q[i] == 4'h0);
                hi_ok     = hi_ok && ((act_code_q[i] == 4'h0) || (act_code_q[i] == 4'hF));
            end
        end
`endif
    end

    // Display output values for the current scan position
    always_comb begin
        an_d   = '1;
        seg_d  = 7'h7F;
        dp_d   = 1'b1;
        tick_d = frame_end;
        if (cnt_q >= CNT_GUARD) begin
            an_d[idx_q] = 1'b0;
            if (!(act_blank_q[idx_q] || (act_blink_q[idx_q] && blink_ph_q))) begin
                seg_d = lz_sup[idx_q] ? 7'h7F : decode(act_code_q[idx_q]);
                dp_d  = ~act_dp_q[idx_q];
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            blk_cnt_q   <= '0;
            blink_ph_q  <= 1'b0;
            pending_q   <= 1'b0;
            sh_code_q   <= '1;
            act_code_q  <= '1;
            sh_dp_q     <= '0;
            sh_blank_q  <= '0;
            sh_blink_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '0;
            act_blink_q <= '0;
            an_q        <= '1;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            blk_cnt_q   <= blk_cnt_d;
            blink_ph_q  <= blink_ph_d;
            pending_q   <= pending_d;
            sh_code_q   <= sh_code_d;
            act_code_q  <= act_code_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            sh_blink_q  <= sh_blink_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            act_blink_q <= act_blink_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            tick_q      <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode 7-segment display: latches per-digit 4-bit codes, scans one digit per refresh slot, and drives shared active-low cathodes plus per-digit active-low anodes.
- Adds frame-synchronous (tear-free) update, per-digit blank/blink/decimal point, and anti-ghosting guard time.
- Sits between the game controller (scores, "FAIL", "-" prompts) and the board display pins.

Parameters:
- NUM_DIGITS, 4: digits scanned; legal range 1..8.
- REFRESH_DIV, 100000: clock cycles per digit slot; minimum 2.
- GUARD_CYCLES, 2000: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- BLINK_FRAMES, 50: full scan frames per blink half-period; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  single-cycle strobe; captures digits/dp_in/blank_mask/blink_mask into the shadow set
- digits  in  4*NUM_DIGITS  codes, nibble i = digit i (digit 0 rightmost, an[0])
- dp_in  in  NUM_DIGITS  1 = decimal point lit on digit i
- blank_mask  in  NUM_DIGITS  1 = digit i forced dark (segments and dp)
- blink_mask  in  NUM_DIGITS  1 = digit i dark during blink phase 1
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal-point cathode, active low
- an  out  NUM_DIGITS  anodes, active low, at most one low at any time
- frame_tick  out  1  one-cycle pulse on the last cycle of each full frame

Behaviour:
- Reset (async, active-high):
  - an all 1, seg 7'h7F, dp 1, frame_tick 0.
  - slot counter 0, scan index 0, blink phase 0, pending 0.
  - Shadow and active code sets = 4'hF; all masks 0.
- Decode table:
  - 0-9: numerals. A=4'hA, L=4'hB, I=4'hC (drawn as 1), F=4'hD, '-'=4'hE.
  - 4'hF: blank (7'h7F).
  - Patterns active-low; bit 0 = segment a.
- Slot counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, scan index advances modulo NUM_DIGITS.
  - Frame end = index NUM_DIGITS-1 and counter REFRESH_DIV-1.
- Outputs are registered, one cycle of latency from counter/index state:
  - counter < GUARD_CYCLES: an all 1, seg 7'h7F, dp 1.
  - otherwise an[index] = 0, all other anodes 1.
  - seg = decode(active code[index]).
  - dp = ~active dp[index].
- Darkening:
  - If active blank[index], or (active blink[index] and blink phase 1), seg = 7'h7F and dp = 1.
  - The anode still follows the scan so brightness stays uniform.
- load: shadow <= inputs, pending <= 1. Repeated loads before frame end overwrite the shadow; last one wins.
- Frame end with pending = 1: active <= shadow, pending <= 0.
  - If load coincides with frame end, the incoming inputs go straight to active and pending stays 0.
- Blink:
  - A frame counter counts 0..BLINK_FRAMES-1 on frame end.
  - Blink phase toggles when it wraps.
  - A commit does not reset the blink phase.
- frame_tick: registered, high for exactly the one cycle after the frame-end state, aligned with the output update.
- NUM_DIGITS = 1: index stays 0, every slot wrap is a frame end, an[0] toggles only for guard.
- Reset mid-scan: all outputs dark immediately (async); scanning resumes from digit 0, counter 0 on the first clock after release.

Optional Feature:
- LEADING_ZERO_BLANK_EN defined:
  - During display, any active digit i > 0 whose code is 0, and every higher-index code is 0 or 4'hF, is shown blank.
  - Digit 0 is never suppressed.
  - Decimal points are still shown.
- Not defined: zeros are always displayed as 0.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=1, BLINK_FRAMES=2):
- Reset release, no load -> an cycles 1110,1101,1011,0111 every 8 cycles with 1 dark guard cycle each; seg stays 7'h7F; frame_tick every 32 cycles.
- load digits=16'h1234 mid-frame -> old codes until next frame_tick; then the slot with an=1110 shows 7'b0011001 (4) and the slot with an=0111 shows 7'b1111001 (1).
- load digits=16'hABCD, dp_in=4'b0010 -> digit 1 shows 7'b1111001 (I) with dp=0; digit 3 shows 7'b0001000 (A); all other slots dp=1.
- blink_mask=4'b0001, digits=16'h0008 -> digit 0 shows 7'b0000000 for 2 frames, then 7'h7F for 2 frames, repeating; other digits unaffected.
- load asserted on the exact frame-end cycle with digits=16'hEEEE -> the following frame shows '-' (7'b0111111) on all four digits; no extra frame of delay.
- rst pulsed mid-slot on digit 2 -> an=1111 and seg=7'h7F with no clock edge; after release, digit 0 is the first slot; with LEADING_ZERO_BLANK_EN and 16'h0050, digits 3 and 2 are dark and digits 1 and 0 show 5 and 0.
